// File: rtl/vend_fsm_multi_if.sv
// Vending controller bus: coin/selection/cancel inputs, dispenser
// valid/ack handshake, and credit/status outputs.
// Ports (master = front panel + dispenser side, slave = controller):
//   coin_valid, coin_code[1:0], sel_valid, sel_idx[2:0], cancel, disp_ack
//   disp_valid, disp_idx[2:0], credit[CREDIT_W-1:0], change_pulse,
//   coin_reject, sel_deny, busy
interface vend_fsm_multi_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                sel_valid;
    logic [2:0]          sel_idx;
    logic                cancel;
    logic                disp_ack;
    logic                disp_valid;
    logic [2:0]          disp_idx;
    logic [CREDIT_W-1:0] credit;
    logic                change_pulse;
    logic                coin_reject;
    logic                sel_deny;
    logic                busy;

    modport master (
        output coin_valid, coin_code, sel_valid, sel_idx,
        output cancel, disp_ack,
        input  disp_valid, disp_idx, credit, change_pulse,
        input  coin_reject, sel_deny, busy
    );

    modport slave (
        input  coin_valid, coin_code, sel_valid, sel_idx,
        input  cancel, disp_ack,
        output disp_valid, disp_idx, credit, change_pulse,
        output coin_reject, sel_deny, busy
    );
endinterface

// File: rtl/vend_fsm_multi.sv
// Multi-product vending FSM: multi-denomination credit, per-product
// prices, valid/ack vend handshake, unit change pulses, idle refund.
// Ports: clk, rst (sync, active-high), bus (vend_fsm_multi_if.slave).
module vend_fsm_multi #(
    parameter int                  CREDIT_W    = 4,
    parameter int                  NUM_PROD    = 4,
    parameter logic [8*CREDIT_W-1:0] PRICES    = 32'h00007532,
    parameter int                  MAX_CREDIT  = 12,
    parameter int                  TIMEOUT_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    vend_fsm_multi_if.slave      bus
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W:0] MAXC = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [3:0] NP = 4'(NUM_PROD);

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        VEND,
        CHANGE
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [2:0]          idx_q, idx_d;
    logic                dv_q, dv_d;
    logic                chg_q, chg_d;
    logic                rej_q, rej_d;
    logic                deny_q, deny_d;

    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] price;
    logic                sel_ok;

    always_comb begin
        coin_val = '0;
        case (bus.coin_code)
            2'd0:    coin_val = (CREDIT_W + 1)'(1);
            2'd1:    coin_val = (CREDIT_W + 1)'(2);
            2'd2:    coin_val = (CREDIT_W + 1)'(5);
            default: coin_val = '0;
        endcase
    end

    // Sum is one bit wider so an overflowing coin is caught, not wrapped.
    assign sum     = {1'b0, credit_q} + coin_val;
    assign coin_ok = (bus.coin_code != 2'd3) && (sum <= MAXC);

    assign price  = PRICES[32'(bus.sel_idx) * CREDIT_W +: CREDIT_W];
    assign sel_ok = ({1'b0, bus.sel_idx} < NP) && (credit_q >= price);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            tmr_q    <= '0;
            idx_q    <= '0;
            dv_q     <= 1'b0;
            chg_q    <= 1'b0;
            rej_q    <= 1'b0;
            deny_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
            dv_q     <= dv_d;
            chg_q    <= chg_d;
            rej_q    <= rej_d;
            deny_q   <= deny_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        tmr_d    = tmr_q;
        idx_d    = idx_q;
        dv_d     = dv_q;
        chg_d    = 1'b0;
        rej_d    = 1'b0;
        deny_d   = 1'b0;

        unique case (state_q)
            IDLE, CREDIT: begin
                if (bus.cancel) begin
                    rej_d   = bus.coin_valid;
                    tmr_d   = '0;
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
                end else if (bus.sel_valid) begin
                    // A denied select is still activity: timer holds.
                    rej_d = bus.coin_valid;
                    if (sel_ok) begin
                        credit_d = credit_q - price;
                        idx_d    = bus.sel_idx;
                        dv_d     = 1'b1;
                        tmr_d    = '0;
                        state_d  = VEND;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (bus.coin_valid && coin_ok) begin
                    credit_d = sum[CREDIT_W-1:0];
                    tmr_d    = '0;
                    state_d  = CREDIT;
                end else begin
                    rej_d = bus.coin_valid;
                    if (state_q == CREDIT) begin
                        if (tmr_q == TLAST) begin
                            tmr_d   = '0;
                            state_d = (credit_q != '0) ? CHANGE : IDLE;
                        end else begin
                            tmr_d = tmr_q + TW'(1);
                        end
                    end
                end
            end

            VEND: begin
                rej_d = bus.coin_valid;
                if (bus.disp_ack) begin
                    dv_d    = 1'b0;
                    idx_d   = '0;
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
                end
            end

            CHANGE: begin
                rej_d = bus.coin_valid;
                if (credit_q != '0) begin
                    chg_d    = 1'b1;
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.disp_valid   = dv_q;
    assign bus.disp_idx     = idx_q;
    assign bus.credit       = credit_q;
    assign bus.change_pulse = chg_q;
    assign bus.coin_reject  = rej_q;
    assign bus.sel_deny     = deny_q;
    assign bus.busy         = (state_q == VEND) || (state_q == CHANGE);
endmodule
